ship_board_mem: RTL and testbench
=================================

Name: ship_board_mem

Overview:
- Board-state store and pixel server for one 10x10 battleship grid.
- Write side: game logic places ships and fires shots through a req/ack command port; each command returns a result code.
- Read side: the ship renderer supplies a cell index and glyph line; the block returns a 32-bit pixel row with fixed 2-cycle latency.
- A clear sequencer wipes the board between games.

Parameters:
- GRID_DIM, 10, cells per board side.
- CELLS, 100, total cells (GRID_DIM*GRID_DIM); valid indices 0..CELLS-1.
- SHIP_CELLS, 20, maximum ship cells that may be placed; the all-sunk threshold.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rd_xy  in  7  cell index requested by the renderer.
- rd_line  in  5  glyph row within the cell, 0..31.
- ship_pixels  out  32  glyph row for (rd_xy, rd_line); bit 31 = leftmost pixel.
- wr_req  in  1  command request; held high until wr_ack.
- wr_xy  in  7  target cell of the command.
- wr_op  in  2  command: 0 = PLACE, 1 = SHOOT, 2/3 reserved (REJECT).
- wr_ack  out  1  one-cycle pulse; command complete.
- wr_result  out  2  0 = OK, 1 = HIT, 2 = MISS, 3 = REJECT; valid with wr_ack, held until the next ack.
- clr_req  in  1  request a board clear; single pulse or level.
- busy  out  1  high when the FSM is not in IDLE.
- ship_cnt  out  5  placed ship cells.
- hit_cnt  out  5  ship cells hit.
- all_sunk  out  1  registered; 1 when hit_cnt == ship_cnt and ship_cnt != 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: every cell EMPTY; ship_pixels = 0, wr_ack = 0, wr_result = 0, busy = 0, ship_cnt = 0, hit_cnt = 0, all_sunk = 0; FSM in IDLE. Reset mid-CLEAR or mid-command aborts it with no ack.
- Cell state encoding: 2 bits: EMPTY = 0, SHIP = 1, HIT = 2, MISS = 3. Storage is CELLS x 2-bit registers.
- Read pipeline: fixed 2 cycles, fully pipelined, one new request per cycle.
  - Stage 1 registers the cell state and rd_line. rd_xy >= CELLS reads as EMPTY.
  - Stage 2 registers the glyph ROM output into ship_pixels.
  - The read port is independent of the FSM. A write to a cell becomes visible to reads issued the cycle after the write cycle.
- Glyphs (row value by line):
  - EMPTY: 0 on every line.
  - SHIP: 32'h7FFF_FFFE on lines 1..30, 0 on lines 0 and 31.
  - HIT: SHIP pattern OR bit(31-line) OR bit(line); forms an X.
  - MISS: 32'h000F_F000 on lines 12..19, else 0.
- FSM states: IDLE, CLEAR, EXEC, ACK.
  - IDLE with clr_req = 1: go to CLEAR. clr_req has priority over wr_req when both are high in the same cycle.
  - IDLE with wr_req = 1 (and clr_req = 0): latch wr_xy and wr_op, go to EXEC.
  - CLEAR: counter 0..CELLS-1 writes one cell EMPTY per cycle (CELLS cycles total). ship_cnt and hit_cnt are zeroed on entry. Then go to IDLE. wr_req is ignored during CLEAR and stays pending.
  - EXEC: read-modify-write of one cell and the counters, result registered, go to ACK.
  - ACK: wr_ack = 1 for one cycle, go to IDLE. A wr_req still high in the following IDLE cycle is taken as a new command; the requester must drop wr_req on ack.
- Command rules:
  - wr_xy >= CELLS or reserved op: REJECT, no change.
  - PLACE on EMPTY with ship_cnt < SHIP_CELLS: cell becomes SHIP, ship_cnt++, result OK.
  - PLACE otherwise (cell occupied or ship_cnt at limit): REJECT.
  - SHOOT on SHIP: cell becomes HIT, hit_cnt++, result HIT.
  - SHOOT on EMPTY: cell becomes MISS, result MISS.
  - SHOOT on HIT or MISS: REJECT, no change.
- Latency: wr_req sampled in cycle n gives wr_ack in cycle n+2. Counters saturate and never wrap.

Optional Feature:
- Macro: SHIP_BOARD_FOG_EN.
- Defined: stage 1 maps SHIP to EMPTY before the glyph ROM, so the enemy board hides unhit ships. Commands, counters and all_sunk are unchanged.
- Undefined: all states are rendered as stored.

Decomposition:
- Shared package (ship_pkg): cell_state_t enum; wr_op_t and wr_result_t enums; glyph constants GLYPH_SHIP, GLYPH_MISS; GRID_DIM/CELLS defaults.
- One sub-module, ship_glyph_rom: combinational function of (cell_state_t, line[4:0]) returning the 32-bit row. Instantiated between the two read stages.

Test Plan:
- Reset, then read idx 0, line 5 -> ship_pixels = 0 two cycles later; busy = 0, all counters 0.
- PLACE at 23 -> wr_ack at n+2, result OK, ship_cnt = 1; read idx 23, line 5 -> 32'h7FFF_FFFE; line 0 -> 0. Second PLACE at 23 -> REJECT, ship_cnt stays 1.
- SHOOT 23 -> HIT, hit_cnt = 1, all_sunk = 1; read line 3 -> 32'h7FFF_FFFE | bit28 | bit3. SHOOT 23 again -> REJECT.
- SHOOT 50 (empty) -> MISS; read line 12 -> 32'h000F_F000, line 11 -> 0. SHOOT 100 -> REJECT.
- clr_req and wr_req in the same cycle -> busy high for exactly 100 cycles, counters 0, all cells read 0; the pending PLACE is then executed with result OK.
- Place 20 cells, then a 21st PLACE -> REJECT. Assert rst mid-CLEAR -> all outputs at reset values immediately. With SHIP_BOARD_FOG_EN, a SHIP cell reads 0.

Source files
------------

// File: rtl/ship_pkg.sv
// rtl/ship_pkg.sv - shared types and constants for the battleship board store
package ship_pkg;

  localparam int GRID_DIM   = 10;
  localparam int CELLS      = GRID_DIM * GRID_DIM;
  localparam int SHIP_CELLS = 20;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SHIP  = 2'd1,
    CELL_HIT   = 2'd2,
    CELL_MISS  = 2'd3
  } cell_state_t;

  typedef enum logic [1:0] {
    OP_PLACE = 2'd0,
    OP_SHOOT = 2'd1,
    OP_RSVD2 = 2'd2,
    OP_RSVD3 = 2'd3
  } wr_op_t;

  typedef enum logic [1:0] {
    RES_OK     = 2'd0,
    RES_HIT    = 2'd1,
    RES_MISS   = 2'd2,
    RES_REJECT = 2'd3
  } wr_result_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_EXEC  = 2'd2,
    ST_ACK   = 2'd3
  } fsm_state_t;

  localparam logic [31:0] GLYPH_SHIP = 32'h7FFF_FFFE;
  localparam logic [31:0] GLYPH_MISS = 32'h000F_F000;

endpackage

// File: rtl/ship_glyph_rom.sv
// rtl/ship_glyph_rom.sv - combinational glyph row lookup per cell state and line
module ship_glyph_rom
  import ship_pkg::*;
(
  input  cell_state_t  state,
  input  logic [4:0]   line,
  output logic [31:0]  pixels
);

  logic [31:0] ship_row;
  logic [31:0] diag;

  // Pick the glyph row; HIT overlays an X on the ship body
  always_comb begin
    ship_row = (line != 5'd0 && line != 5'd31) ? GLYPH_SHIP : 32'h0;
    diag = 32'h0;
    diag[5'd31 - line] = 1'b1;
    diag[line] = 1'b1;
    pixels = 32'h0;
    case (state)
      CELL_SHIP: pixels = ship_row;
      CELL_HIT:  pixels = ship_row | diag;
      CELL_MISS: pixels = (line >= 5'd12 && line <= 5'd19) ? GLYPH_MISS : 32'h0;
      default:   pixels = 32'h0;
    endcase
  end

endmodule

// File: rtl/ship_board_mem.sv
// rtl/ship_board_mem.sv - board store, command FSM and 2-cycle pixel server; SHIP_BOARD_FOG_EN hides unhit ships
module ship_board_mem
  import ship_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  rd_xy,
  input  logic [4:0]  rd_line,
  output logic [31:0] ship_pixels,
  input  logic        wr_req,
  input  logic [6:0]  wr_xy,
  input  logic [1:0]  wr_op,
  output logic        wr_ack,
  output logic [1:0]  wr_result,
  input  logic        clr_req,
  output logic        busy,
  output logic [4:0]  ship_cnt,
  output logic [4:0]  hit_cnt,
  output logic        all_sunk
);

  cell_state_t cells [CELLS];
  fsm_state_t  state, state_nxt;
  logic [6:0]  clr_idx;
  logic [6:0]  cmd_xy;
  wr_op_t      cmd_op;

  cell_state_t rd_cell;
  cell_state_t s1_state;
  logic [4:0]  s1_line;
  logic [31:0] rom_row;

  cell_state_t cur_cell;
  cell_state_t ex_val;
  logic        ex_we;
  wr_result_t  ex_res;
  logic        ship_inc, hit_inc;
  logic [4:0]  ship_nxt, hit_nxt;

  // Read-side cell lookup; out-of-range indices read as empty water
  always_comb begin
    rd_cell = CELL_EMPTY;
    if (rd_xy < 7'(CELLS)) rd_cell = cells[rd_xy];
`ifdef SHIP_BOARD_FOG_EN
    if (rd_cell == CELL_SHIP) rd_cell = CELL_EMPTY;
`endif
  end

  // Read stage 1: capture cell state and glyph line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_state <= CELL_EMPTY;
      s1_line  <= 5'd0;
    end else begin
      s1_state <= rd_cell;
      s1_line  <= rd_line;
    end
  end

  ship_glyph_rom u_rom (
    .state  (s1_state),
    .line   (s1_line),
    .pixels (rom_row)
  );

  // Read stage 2: register the glyph row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ship_pixels <= 32'h0;
    else     ship_pixels <= rom_row;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state; a clear wins over a simultaneous command
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (clr_req)     state_nxt = ST_CLEAR;
        else if (wr_req) state_nxt = ST_EXEC;
      end
      ST_CLEAR: if (clr_idx == 7'(CELLS - 1)) state_nxt = ST_IDLE;
      ST_EXEC:  state_nxt = ST_ACK;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (state != ST_IDLE);
    wr_ack = (state == ST_ACK);
  end

  // Command decode: resulting cell value, result code and counter bumps
  always_comb begin
    cur_cell = CELL_EMPTY;
    if (cmd_xy < 7'(CELLS)) cur_cell = cells[cmd_xy];
    ex_we    = 1'b0;
    ex_val   = cur_cell;
    ex_res   = RES_REJECT;
    ship_inc = 1'b0;
    hit_inc  = 1'b0;
    if (cmd_xy < 7'(CELLS)) begin
      case (cmd_op)
        OP_PLACE: begin
          if (cur_cell == CELL_EMPTY && ship_cnt < 5'(SHIP_CELLS)) begin
            ex_we = 1'b1; ex_val = CELL_SHIP; ex_res = RES_OK; ship_inc = 1'b1;
          end
        end
        OP_SHOOT: begin
          if (cur_cell == CELL_SHIP) begin
            ex_we = 1'b1; ex_val = CELL_HIT; ex_res = RES_HIT; hit_inc = 1'b1;
          end else if (cur_cell == CELL_EMPTY) begin
            ex_we = 1'b1; ex_val = CELL_MISS; ex_res = RES_MISS;
          end
        end
        default: ex_res = RES_REJECT;
      endcase
    end
  end

  // Counter next values; zeroed when a clear starts, saturating on increment
  always_comb begin
    ship_nxt = ship_cnt;
    hit_nxt  = hit_cnt;
    if (state == ST_IDLE && clr_req) begin
      ship_nxt = 5'd0;
      hit_nxt  = 5'd0;
    end else if (state == ST_EXEC) begin
      if (ship_inc && ship_cnt != 5'd31) ship_nxt = ship_cnt + 5'd1;
      if (hit_inc && hit_cnt != 5'd31)   hit_nxt  = hit_cnt + 5'd1;
    end
  end

  // Board storage, clear sweep, command latch, counters and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) cells[i] <= CELL_EMPTY;
      clr_idx   <= 7'd0;
      cmd_xy    <= 7'd0;
      cmd_op    <= OP_PLACE;
      ship_cnt  <= 5'd0;
      hit_cnt   <= 5'd0;
      all_sunk  <= 1'b0;
      wr_result <= 2'd0;
    end else begin
      ship_cnt <= ship_nxt;
      hit_cnt  <= hit_nxt;
      all_sunk <= (hit_nxt == ship_nxt) && (ship_nxt != 5'd0);
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            clr_idx <= 7'd0;
          end else if (wr_req) begin
            cmd_xy <= wr_xy;
            cmd_op <= wr_op_t'(wr_op);
          end
        end
        ST_CLEAR: begin
          cells[clr_idx] <= CELL_EMPTY;
          clr_idx <= clr_idx + 7'd1;
        end
        ST_EXEC: begin
          if (ex_we) cells[cmd_xy] <= ex_val;
          wr_result <= ex_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ship_board_mem.sv
// tb/tb_ship_board_mem.sv - randomized self-checking bench against a board-level model
module tb_ship_board_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  rd_xy, wr_xy;
  logic [4:0]  rd_line;
  logic [31:0] ship_pixels;
  logic        wr_req, wr_ack, clr_req, busy, all_sunk;
  logic [1:0]  wr_op, wr_result;
  logic [4:0]  ship_cnt, hit_cnt;

  always #5 clk = ~clk;

  ship_board_mem dut (
    .clk(clk), .rst(rst),
    .rd_xy(rd_xy), .rd_line(rd_line), .ship_pixels(ship_pixels),
    .wr_req(wr_req), .wr_xy(wr_xy), .wr_op(wr_op),
    .wr_ack(wr_ack), .wr_result(wr_result),
    .clr_req(clr_req), .busy(busy),
    .ship_cnt(ship_cnt), .hit_cnt(hit_cnt), .all_sunk(all_sunk)
  );

  int total = 0;
  int bad = 0;

  // model: board contents, counters, last result and the command/clear timeline
  int board [100];
  int m_ship, m_hit, m_res;
  int m_clr;
  int m_stage;
  int m_xy, m_op;
  logic [31:0] pa, pb;

  function automatic logic [31:0] glyph(input int st_in, input int line);
    logic [31:0] row;
    int st;
    st = st_in;
`ifdef SHIP_BOARD_FOG_EN
    if (st == 1) st = 0;
`endif
    row = 32'h0;
    case (st)
      1: if (line >= 1 && line <= 30) row = 32'h7FFF_FFFE;
      2: begin
        if (line >= 1 && line <= 30) row = 32'h7FFF_FFFE;
        row = row | (32'h1 << (31 - line)) | (32'h1 << line);
      end
      3: if (line >= 12 && line <= 19) row = 32'h000F_F000;
      default: row = 32'h0;
    endcase
    return row;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 100; i++) board[i] = 0;
    m_ship = 0; m_hit = 0; m_res = 0; m_clr = -1; m_stage = 0;
    m_xy = 0; m_op = 0; pa = 32'h0; pb = 32'h0;
  endtask

  task automatic model_exec();
    if (m_xy >= 100 || m_op > 1) m_res = 3;
    else if (m_op == 0) begin
      if (board[m_xy] == 0 && m_ship < 20) begin
        board[m_xy] = 1; m_ship++; m_res = 0;
      end else m_res = 3;
    end else begin
      if (board[m_xy] == 1) begin board[m_xy] = 2; m_hit++; m_res = 1; end
      else if (board[m_xy] == 0) begin board[m_xy] = 3; m_res = 2; end
      else m_res = 3;
    end
  endtask

  // one cycle: check current outputs, drive next inputs, advance model past the edge
  task automatic cyc(input int rx, input int rl, input logic wreq, input int wx, input int wo, input logic creq);
    chk("busy", busy, (m_clr >= 0 || m_stage != 0));
    chk("wr_ack", wr_ack, (m_stage == 2));
    chk("wr_result", wr_result, m_res);
    chk("ship_cnt", ship_cnt, m_ship);
    chk("hit_cnt", hit_cnt, m_hit);
    chk("all_sunk", all_sunk, (m_hit == m_ship && m_ship != 0));
    chk("pixels", ship_pixels, pb);
    pb = pa;
    rd_xy = rx[6:0]; rd_line = rl[4:0];
    wr_req = wreq; wr_xy = wx[6:0]; wr_op = wo[1:0]; clr_req = creq;
    pa = (rx < 100) ? glyph(board[rx], rl) : glyph(0, rl);
    if (m_stage == 2) m_stage = 0;
    else if (m_stage == 1) begin model_exec(); m_stage = 2; end
    else if (m_clr >= 0) begin
      board[m_clr] = 0; m_clr++;
      if (m_clr == 100) m_clr = -1;
    end else if (creq) begin m_clr = 0; m_ship = 0; m_hit = 0; end
    else if (wreq) begin m_xy = wx; m_op = wo; m_stage = 1; end
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    cyc($urandom_range(0, 127), $urandom_range(0, 31), 1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_cmd(input int xy, input int op, input int exp_res);
    int n;
    n = 0;
    while (m_stage != 2 && n < 50) begin
      cyc($urandom_range(0, 127), $urandom_range(0, 31), 1'b1, xy, op, 1'b0);
      n++;
    end
    chk("cmd_latency", n, 2);
    chk("cmd_result", wr_result, exp_res);
    idle_cyc();
  endtask

  task automatic read_lit(input int xy, input int line, input logic [31:0] exp);
    cyc(xy, line, 1'b0, 0, 0, 1'b0);
    idle_cyc();
    chk("read_lit", ship_pixels, exp);
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    logic pend;
    logic req;
    int rxy, rop;
    rst = 1'b1; rd_xy = 0; rd_line = 0; wr_req = 0; wr_xy = 0; wr_op = 0; clr_req = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ship_cnt", ship_cnt, 0);
    read_lit(0, 5, 32'h0);

    do_cmd(23, 0, 0);
    chk("place_cnt", ship_cnt, 1);
`ifdef SHIP_BOARD_FOG_EN
    read_lit(23, 5, 32'h0);
`else
    read_lit(23, 5, 32'h7FFF_FFFE);
`endif
    read_lit(23, 0, 32'h0);
    do_cmd(23, 0, 3);
    chk("dup_place_cnt", ship_cnt, 1);

    do_cmd(23, 1, 1);
    chk("hit_cnt_1", hit_cnt, 1);
    chk("all_sunk_1", all_sunk, 1);
    read_lit(23, 3, 32'h7FFF_FFFE);
    read_lit(23, 0, 32'h8000_0001);
    do_cmd(23, 1, 3);

    do_cmd(50, 1, 2);
    read_lit(50, 12, 32'h000F_F000);
    read_lit(50, 11, 32'h0);
    do_cmd(100, 1, 3);
    do_cmd(5, 2, 3);

    // clear and place in the same cycle: clear wins, place stays pending
    cyc(0, 0, 1'b1, 23, 0, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      cyc(0, 0, 1'b1, 23, 0, 1'b0);
      n++;
    end
    chk("clear_len", n, 100);
    chk("clear_ship_cnt", ship_cnt, 0);
    chk("clear_hit_cnt", hit_cnt, 0);
    pend = 1'b1;
    for (int i = 0; i < 102; i++) begin
      if (m_stage == 2 && pend) begin
        chk("pending_place", wr_result, 0);
        pend = 1'b0;
      end
      cyc((i < 100) ? i : 0, 0, pend, 23, 0, 1'b0);
      if (i >= 2) chk("clear_read", ship_pixels, 32'h0);
    end
    chk("pending_cnt", ship_cnt, 1);

    for (int i = 60; i < 79; i++) do_cmd(i, 0, 0);
    chk("full_cnt", ship_cnt, 20);
    do_cmd(79, 0, 3);
    chk("over_cnt", ship_cnt, 20);

    // reset in the middle of a clear
    cyc(0, 0, 1'b0, 0, 0, 1'b1);
    repeat (30) idle_cyc();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ship", ship_cnt, 0);
    chk("mid_rst_hit", hit_cnt, 0);
    chk("mid_rst_sunk", all_sunk, 0);
    chk("mid_rst_ack", wr_ack, 0);
    chk("mid_rst_res", wr_result, 0);
    chk("mid_rst_pix", ship_pixels, 32'h0);
    model_reset();
    rd_xy = 0; rd_line = 0; wr_req = 0; clr_req = 0;
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    req = 1'b0; rxy = 0; rop = 0;
    for (int c = 0; c < 4000; c++) begin
      if (req && m_stage == 2) req = 1'b0;
      else if (!req && $urandom_range(0, 2) == 0) begin
        req = 1'b1;
        rxy = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 127) : $urandom_range(0, 99);
        rop = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
      end
      cyc($urandom_range(0, 127), $urandom_range(0, 31), req, rxy, rop,
          ($urandom_range(0, 499) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
